// File: rtl/mem_ctrl_pkg.sv
// Purpose : shared types and encodings for the matrix write controller and
//           future read-side blocks (state enum, width selects, Ctrl bits).
// Latency : n/a (declarations only).
// Backpr. : n/a.
package mem_ctrl_pkg;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR0  = 3'd1,
        ST_WR1  = 3'd2,
        ST_WR2  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // IndexCtrl encodings selecting the matrix row width.
    localparam logic [1:0] IDX_W3   = 2'b00;
    localparam logic [1:0] IDX_W64  = 2'b01;
    localparam logic [1:0] IDX_W128 = 2'b10;
    localparam logic [1:0] IDX_W256 = 2'b11;

    // Row widths matching the encodings above.
    localparam int unsigned WIDTH_W3   = 3;
    localparam int unsigned WIDTH_W64  = 64;
    localparam int unsigned WIDTH_W128 = 128;
    localparam int unsigned WIDTH_W256 = 256;

    // Shift amounts for the power-of-two widths (row * 2^n == row << n).
    localparam int unsigned SHIFT_W64  = 6;
    localparam int unsigned SHIFT_W128 = 7;
    localparam int unsigned SHIFT_W256 = 8;

    // Ctrl bit positions.
    localparam int unsigned CTRL_TRIPLE_BIT = 0;  // 0 = single write, 1 = triple write
    localparam int unsigned CTRL_VERT_BIT   = 1;  // triple only: 0 = horizontal, 1 = vertical

endpackage : mem_ctrl_pkg

// File: rtl/index_addr_calc.sv
// Purpose : linear word address from (row, col) for a row width selected by
//           IndexCtrl: addr = row * W + col, 32-bit, truncating.
// Latency : combinational. Backpr.: none (pure function).
// Ports   : i_row/i_col 16-bit indices, i_index_ctrl width select,
//           o_addr 32-bit address.
module index_addr_calc
    import mem_ctrl_pkg::*;
(
    input  logic [15:0] i_row,
    input  logic [15:0] i_col,
    input  logic [1:0]  i_index_ctrl,
    output logic [31:0] o_addr
);

    logic [31:0] w_row32;
    logic [31:0] w_row_scaled;

    assign w_row32 = {16'h0000, i_row};

    // No multiplier: width 3 is row*2 + row, the rest are plain shifts.
    always_comb begin
        w_row_scaled = 32'h0000_0000;
        case (i_index_ctrl)
            IDX_W3:   w_row_scaled = (w_row32 << 1) + w_row32;
            IDX_W64:  w_row_scaled = w_row32 << SHIFT_W64;
            IDX_W128: w_row_scaled = w_row32 << SHIFT_W128;
            IDX_W256: w_row_scaled = w_row32 << SHIFT_W256;
            default:  w_row_scaled = 32'h0000_0000;
        endcase
    end

    assign o_addr = w_row_scaled + {16'h0000, i_col};

endmodule : index_addr_calc

// File: rtl/memory_write_controller.sv
// Purpose : writes one word, or three words along a matrix row/column, into a
//           linear memory, then completes a four-phase ENABLE/HANDSHAKE.
// Latency : HANDSHAKE rises 2 (single) or 4 (triple) cycles after acceptance.
// Backpr. : requester holds ENABLE until HANDSHAKE; DONE waits for ENABLE low.
// Ports   : CLK, RESET (async, active-high); request ENABLE/Ctrl/IndexCtrl/
//           ADDRESS (row[31:16], col[15:0]) /WRITE (3 x 16-bit); memory side
//           AddressMem/WriteMem/WriteEnableMem; completion HANDSHAKE.
module memory_write_controller
    import mem_ctrl_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic [1:0]  Ctrl,
    input  logic [1:0]  IndexCtrl,
    input  logic [31:0] ADDRESS,
    input  logic [47:0] WRITE,
    output logic [31:0] AddressMem,
    output logic [15:0] WriteMem,
    output logic        WriteEnableMem,
    output logic        HANDSHAKE
);

    state_t      r_state;
    logic [15:0] r_row;
    logic [15:0] r_col;
    logic [1:0]  r_ctrl;
    logic [1:0]  r_index_ctrl;
    logic [47:0] r_write;

    logic [15:0] w_step;
    logic        w_vertical;
    logic [15:0] w_row;
    logic [15:0] w_col;
    logic [31:0] w_addr;
    logic [15:0] w_word;

    // Offset of the current element from the latched start index.
    always_comb begin
        w_step = 16'd0;
        case (r_state)
            ST_WR1:  w_step = 16'd1;
            ST_WR2:  w_step = 16'd2;
            default: w_step = 16'd0;
        endcase
    end

    // Index increments are 16-bit and wrap naturally.
    assign w_vertical = r_ctrl[CTRL_VERT_BIT];
    assign w_row      = w_vertical ? (r_row + w_step) : r_row;
    assign w_col      = w_vertical ? r_col : (r_col + w_step);

    always_comb begin
        w_word = r_write[15:0];
        case (r_state)
            ST_WR1:  w_word = r_write[31:16];
            ST_WR2:  w_word = r_write[47:32];
            default: w_word = r_write[15:0];
        endcase
    end

    index_addr_calc u_addr_calc (
        .i_row        (w_row),
        .i_col        (w_col),
        .i_index_ctrl (r_index_ctrl),
        .o_addr       (w_addr)
    );

    // Outputs are registered from the current state, so each state's drive
    // appears in the cycle after that state is entered.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state        <= ST_IDLE;
            r_row          <= 16'd0;
            r_col          <= 16'd0;
            r_ctrl         <= 2'd0;
            r_index_ctrl   <= 2'd0;
            r_write        <= 48'd0;
            AddressMem     <= 32'd0;
            WriteMem       <= 16'd0;
            WriteEnableMem <= 1'b0;
            HANDSHAKE      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    AddressMem     <= 32'd0;
                    WriteMem       <= 16'd0;
                    WriteEnableMem <= 1'b0;
                    HANDSHAKE      <= 1'b0;
                    if (ENABLE) begin
                        r_row        <= ADDRESS[31:16];
                        r_col        <= ADDRESS[15:0];
                        r_ctrl       <= Ctrl;
                        r_index_ctrl <= IndexCtrl;
                        r_write      <= WRITE;
                        r_state      <= ST_WR0;
                    end
                end
                ST_WR0, ST_WR1, ST_WR2: begin
                    AddressMem     <= w_addr;
                    WriteMem       <= w_word;
                    WriteEnableMem <= 1'b1;
                    HANDSHAKE      <= 1'b0;
                    if (r_state == ST_WR0) begin
                        r_state <= r_ctrl[CTRL_TRIPLE_BIT] ? ST_WR1 : ST_DONE;
                    end else if (r_state == ST_WR1) begin
                        r_state <= ST_WR2;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    AddressMem     <= 32'd0;
                    WriteMem       <= 16'd0;
                    WriteEnableMem <= 1'b0;
                    HANDSHAKE      <= 1'b1;
                    // A requester that already dropped ENABLE during the burst
                    // sees exactly one HANDSHAKE cycle.
                    if (!ENABLE) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state        <= ST_IDLE;
                    AddressMem     <= 32'd0;
                    WriteMem       <= 16'd0;
                    WriteEnableMem <= 1'b0;
                    HANDSHAKE      <= 1'b0;
                end
            endcase
        end
    end

endmodule : memory_write_controller

// File: tb/tb_memory_write_controller.sv
module tb_memory_write_controller;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ENABLE;
    logic [1:0]  Ctrl;
    logic [1:0]  IndexCtrl;
    logic [31:0] ADDRESS;
    logic [47:0] WRITE;
    logic [31:0] AddressMem;
    logic [15:0] WriteMem;
    logic        WriteEnableMem;
    logic        HANDSHAKE;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_exp;
    int   checks   = 0;
    int   failures = 0;
    int   we_run   = 0;

    memory_write_controller dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .ENABLE         (ENABLE),
        .Ctrl           (Ctrl),
        .IndexCtrl      (IndexCtrl),
        .ADDRESS        (ADDRESS),
        .WRITE          (WRITE),
        .AddressMem     (AddressMem),
        .WriteMem       (WriteMem),
        .WriteEnableMem (WriteEnableMem),
        .HANDSHAKE      (HANDSHAKE)
    );

    always #5 CLK = ~CLK;

    // Reference address: plain multiply, independent of the shift form.
    function automatic logic [31:0] model_addr(input logic [15:0] r, input logic [15:0] c,
                                               input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'b00:   w = 32'd3;
            2'b01:   w = 32'd64;
            2'b10:   w = 32'd128;
            default: w = 32'd256;
        endcase
        return ({16'h0, r} * w) + {16'h0, c};
    endfunction

    task automatic push_expected(input logic [1:0] ctrl, input logic [1:0] idx,
                                 input logic [31:0] addr, input logic [47:0] wr);
        exp_t        e;
        logic [15:0] r;
        logic [15:0] c;
        int          n;
        n = ctrl[0] ? 3 : 1;
        for (int k = 0; k < n; k++) begin
            r = addr[31:16];
            c = addr[15:0];
            if (ctrl[1] && ctrl[0]) r = r + 16'(k);
            else                    c = c + 16'(k);
            e.addr = model_addr(r, c, idx);
            e.data = wr[16*k +: 16];
            sb_q.push_back(e);
        end
    endtask

    // Memory-side monitor: every strobe must match the scoreboard head;
    // address/data must be zero whenever the strobe is low.
    always @(negedge CLK) begin
        if (RESET === 1'b0) begin
            if (WriteEnableMem === 1'b1) begin
                we_run++;
                checks++;
                if (we_run > 3) begin
                    failures++;
                    $display("FAIL we_run_length: got %0d required <=3", we_run);
                end
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write: got addr=%0d data=%h required no write",
                             AddressMem, WriteMem);
                end else begin
                    mon_exp = sb_q.pop_front();
                    if ({AddressMem, WriteMem} !== {mon_exp.addr, mon_exp.data}) begin
                        failures++;
                        $display("FAIL write_word: got addr=%0d data=%h required addr=%0d data=%h",
                                 AddressMem, WriteMem, mon_exp.addr, mon_exp.data);
                    end
                end
            end else begin
                we_run = 0;
                checks++;
                if (AddressMem !== 32'd0 || WriteMem !== 16'd0) begin
                    failures++;
                    $display("FAIL idle_outputs_zero: got addr=%0d data=%h required 0/0",
                             AddressMem, WriteMem);
                end
            end
        end else begin
            we_run = 0;
        end
    end

    // One request; drop_at < 0 holds ENABLE until HANDSHAKE, otherwise ENABLE
    // falls at that cycle index after acceptance.
    task automatic run_req(input string name, input logic [1:0] ctrl, input logic [1:0] idx,
                           input logic [31:0] addr, input logic [47:0] wr, input int drop_at);
        int found;
        int lat;
        push_expected(ctrl, idx, addr, wr);
        @(negedge CLK);
        Ctrl = ctrl; IndexCtrl = idx; ADDRESS = addr; WRITE = wr; ENABLE = 1'b1;
        @(posedge CLK);
        #1;
        // Inputs change after acceptance; the latched copies must be used.
        Ctrl = 2'($urandom); IndexCtrl = 2'($urandom);
        ADDRESS = $urandom; WRITE = {16'($urandom), $urandom};
        found = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (HANDSHAKE === 1'b1) begin
                found = i;
                break;
            end
            if (i == drop_at) ENABLE = 1'b0;
        end
        lat = ctrl[0] ? 4 : 2;
        checks++;
        if (found != lat) begin
            failures++;
            $display("FAIL %s_hs_latency: got %0d required %0d", name, found, lat);
        end
        if (drop_at < 0) begin
            repeat (2) begin
                @(negedge CLK);
                checks++;
                if (HANDSHAKE !== 1'b1) begin
                    failures++;
                    $display("FAIL %s_hs_hold: got %b required 1", name, HANDSHAKE);
                end
            end
            ENABLE = 1'b0;
            @(negedge CLK);
            @(negedge CLK);
            checks++;
            if (HANDSHAKE !== 1'b0) begin
                failures++;
                $display("FAIL %s_hs_release: got %b required 0", name, HANDSHAKE);
            end
        end else begin
            ENABLE = 1'b0;
            @(negedge CLK);
            checks++;
            if (HANDSHAKE !== 1'b0) begin
                failures++;
                $display("FAIL %s_hs_one_cycle: got %b required 0", name, HANDSHAKE);
            end
        end
        @(negedge CLK);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL %s_writes_missing: got %0d pending required 0", name, sb_q.size());
        end
        sb_q.delete();
    endtask

    task automatic test_reset();
        RESET = 1'b1; ENABLE = 1'b1;
        Ctrl = 2'b01; IndexCtrl = 2'b11; ADDRESS = 32'h1234_5678; WRITE = 48'hAAAA_BBBB_CCCC;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({AddressMem, WriteMem, WriteEnableMem, HANDSHAKE} !== 50'd0) begin
            failures++;
            $display("FAIL reset_outputs: got addr=%0d data=%h we=%b hs=%b required all 0",
                     AddressMem, WriteMem, WriteEnableMem, HANDSHAKE);
        end
        ENABLE = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_single();
        run_req("single", 2'b00, 2'b01, 32'h0002_0005, 48'h0000_0000_BEEF, -1);
    endtask

    task automatic test_triple_horizontal();
        run_req("triple_h", 2'b01, 2'b00, 32'h0001_0000, 48'h3333_2222_1111, -1);
    endtask

    task automatic test_triple_vertical();
        run_req("triple_v", 2'b11, 2'b10, 32'h0000_0007, 48'hC0DE_5678_9ABC, -1);
    endtask

    task automatic test_wrap();
        run_req("wrap", 2'b01, 2'b11, 32'h0000_FFFF, 48'h0003_0002_0001, -1);
    endtask

    task automatic test_enable_drop();
        run_req("enable_drop", 2'b01, 2'b01, 32'h0003_0010, 48'hDDDD_EEEE_FFFF, 1);
    endtask

    task automatic test_reset_mid_burst();
        exp_t e;
        e.addr = model_addr(16'd4, 16'd9, 2'b10);
        e.data = 16'h0A0A;
        sb_q.push_back(e);
        @(negedge CLK);
        Ctrl = 2'b01; IndexCtrl = 2'b10; ADDRESS = 32'h0004_0009; WRITE = 48'h0C0C_0B0B_0A0A;
        ENABLE = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        @(negedge CLK);   // controller now in WR1, WR0 word on the bus
        #1;
        RESET = 1'b1;
        ENABLE = 1'b0;
        #1;
        checks++;
        if ({AddressMem, WriteMem, WriteEnableMem, HANDSHAKE} !== 50'd0) begin
            failures++;
            $display("FAIL reset_mid_outputs: got addr=%0d data=%h we=%b hs=%b required all 0",
                     AddressMem, WriteMem, WriteEnableMem, HANDSHAKE);
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL reset_mid_wr0_missing: got %0d pending required 0", sb_q.size());
        end
        sb_q.delete();
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            checks++;
            if (WriteEnableMem !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_no_write: got we=%b required 0", WriteEnableMem);
            end
        end
        run_req("after_reset", 2'b00, 2'b00, 32'h0005_0001, 48'h0000_0000_5A5A, -1);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++) begin
            run_req("random", 2'($urandom), 2'($urandom), $urandom,
                    {16'($urandom), $urandom}, (n == 2) ? 0 : -1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_triple_horizontal();
        test_triple_vertical();
        test_wrap();
        test_enable_drop();
        test_reset_mid_burst();
        test_back_to_back();
        repeat (2) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_memory_write_controller
